hilo_muldiv_seq: RTL

- Iterative signed multiply/divide sequencer that owns the HI/LO register pair of the multicycle MIPS datapath.
- The main control unit pulses mult_start or div_start after decode; this block latches the operands and runs one iteration per clock.
- When finished it writes HI/LO, pulses done, and the control FSM leaves its wait state.
- It also flags divide-by-zero so the control unit can take its exception path.

---
 rtl/hilo_muldiv_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_seq.sv
// Iterative signed multiply/divide unit owning the HI/LO register pair.
// Radix-2 Booth multiply and restoring divide, one step per clock.
module hilo_muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StRunMul, StRunDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Booth step: accumulator is widened by one bit so +/- the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  logic [WIDTH:0]     acc_ext, mcand_ext, booth_sum;
  logic [2*WIDTH:0]   prod_step;

  always_comb begin
    acc_ext   = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   booth_sum = acc_ext + mcand_ext;
      2'b10:   booth_sum = acc_ext - mcand_ext;
      default: booth_sum = acc_ext;
    endcase
    prod_step = {booth_sum, prod_q[WIDTH:1]};
  end

  // Restoring divide step on unsigned magnitudes; trial[WIDTH] is the borrow.
  logic [WIDTH:0]     rem_shift, trial;
  logic [WIDTH-1:0]   rem_step, quo_step, quo_fin, rem_fin;
  logic [WIDTH-1:0]   abs_a, abs_b;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fin = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    rem_fin = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
    abs_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      StIdle: begin
        if (mult_start) begin
          mcand_d = a;
          prod_d  = {{WIDTH{1'b0}}, b, 1'b0};
          cnt_d   = CNT_W'(WIDTH);
          state_d = StRunMul;
        end else if (div_start && (b != '0)) begin
          quo_d     = abs_a;
          dvsr_d    = abs_b;
          rem_d     = '0;
          neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          cnt_d     = CNT_W'(WIDTH);
          state_d   = StRunDiv;
        end else if (div_start) begin
          dz_d    = 1'b1;
          state_d = StDone;
        end
      end
      StRunMul: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = prod_step[2*WIDTH:WIDTH+1];
          lo_d    = prod_step[WIDTH:1];
          state_d = StDone;
        end
      end
      StRunDiv: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = rem_fin;
          lo_d    = quo_fin;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign div_zero = (state_q == StDone) && dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
